counter_tick_ctrl: RTL

//   Upstream control stage for up_down_counter. Generates its enable tick with a
//   run-time programmable prescaler. Generates its sel direction level from raw

---
 rtl/counter_tick_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/counter_tick_ctrl.sv
// rtl/counter_tick_ctrl.sv - debounced run/dir/step buttons and prescaled enable tick for up_down_counter
// A STOP/RUN FSM gates the prescaler; in STOP a step press yields exactly one enable cycle.
module counter_tick_ctrl #(
  parameter int DIV_W      = 8,
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             run_btn,
  input  logic             dir_btn,
  input  logic             step_btn,
  output logic             enable,
  output logic             sel,
  output logic             running
);

  localparam int NB = 3;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  logic [NB-1:0]    w_raw;
  logic [NB-1:0]    w_press;
  logic             w_run_ev;
  logic             w_dir_ev;
  logic             w_step_ev;
  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_enable;
  logic             r_sel;
  logic             r_running;

  assign w_raw = {step_btn, dir_btn, run_btn};

  for (genvar b = 0; b < NB; b++) begin : g_btn
    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             w_accept;

    // Press is combinational so the FSM reacts on the same edge the level is accepted.
    assign w_accept   = (r_sync2 != r_stable) && (r_deb_cnt == DEB_LAST);
    assign w_press[b] = w_accept && r_sync2;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_stable  <= 1'b0;
        r_deb_cnt <= '0;
      end else begin
        r_sync1 <= w_raw[b];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_stable) begin
          r_deb_cnt <= '0;
        end else if (w_accept) begin
          r_stable  <= r_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end
    end
  end

  assign w_run_ev  = w_press[0];
  assign w_dir_ev  = w_press[1];
  assign w_step_ev = w_press[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_STOP;
      r_div_cnt <= '0;
      r_enable  <= 1'b0;
      r_sel     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      if (w_dir_ev) begin
        r_sel <= ~r_sel;
      end
      case (r_state)
        ST_STOP: begin
          r_div_cnt <= '0;
          if (w_run_ev) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
            r_enable  <= 1'b0;
          end else begin
            r_enable <= w_step_ev;
          end
        end
        ST_RUN: begin
          // Stop takes priority over a coincident prescaler wrap.
          if (w_run_ev) begin
            r_state   <= ST_STOP;
            r_running <= 1'b0;
            r_div_cnt <= '0;
            r_enable  <= 1'b0;
          end else if (r_div_cnt >= div_ratio) begin
            r_div_cnt <= '0;
            r_enable  <= 1'b1;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_enable  <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_STOP;
          r_running <= 1'b0;
          r_div_cnt <= '0;
          r_enable  <= 1'b0;
        end
      endcase
    end
  end

  assign enable  = r_enable;
  assign sel     = r_sel;
  assign running = r_running;

endmodule
